// File: rtl/aq_umc_spsram_x16_if.sv
// Single-port SRAM access bus: address, active-low controls, write mask/data and registered read data.
// The master drives the access; the slave returns Q.
interface aq_umc_spsram_x16_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] A;
  logic                  CEN;
  logic                  GWEN;
  logic [DATA_WIDTH-1:0] WEN;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] Q;

  modport master (output A, output CEN, output GWEN, output WEN, output D, input Q);
  modport slave  (input A, input CEN, input GWEN, input WEN, input D, output Q);
endinterface

// File: rtl/aq_umc_spsram_x16.sv
// BHT data array: single-port SRAM, bit-masked writes, 1-cycle registered read, no backpressure.
// AQ_SPSRAM_WRITE_THROUGH_EN makes write cycles also load the merged word into Q.
module aq_umc_spsram_x16 #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                CLK,
  input  logic                RST,
  aq_umc_spsram_x16_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] q_r;
  logic [DATA_WIDTH-1:0] merged;

  // Bits with WEN low take D; bits with WEN high keep the stored value.
  assign merged = (mem[bus.A] & bus.WEN) | (bus.D & ~bus.WEN);

  // Array contents are deliberately left out of reset; RST only clears Q and blocks the access.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_r <= '0;
    end else if (!bus.CEN) begin
      if (bus.GWEN) begin
        q_r <= mem[bus.A];
      end else begin
        mem[bus.A] <= merged;
`ifdef AQ_SPSRAM_WRITE_THROUGH_EN
        q_r <= merged;
`endif
      end
    end
  end

  assign bus.Q = q_r;

endmodule

// File: tb/tb_aq_umc_spsram_x16.sv
// Directed bench for aq_umc_spsram_x16 at ADDR_WIDTH 7 and 10.
module tb_aq_umc_spsram_x16;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  aq_umc_spsram_x16_if #(.ADDR_WIDTH(7),  .DATA_WIDTH(16)) s7 ();
  aq_umc_spsram_x16_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) s10 ();

  aq_umc_spsram_x16 #(.ADDR_WIDTH(7), .DATA_WIDTH(16)) dut7 (
    .CLK (clk),
    .RST (rst),
    .bus (s7.slave)
  );

  aq_umc_spsram_x16 #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) dut10 (
    .CLK (clk),
    .RST (rst),
    .bus (s10.slave)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus on the 128-deep instance; returns #1 after the edge.
  task automatic drv7(input logic r, input logic cen, input logic gwen,
                      input logic [6:0] a, input logic [15:0] wen, input logic [15:0] d);
    rst     = r;
    s7.CEN  = cen;
    s7.GWEN = gwen;
    s7.A    = a;
    s7.WEN  = wen;
    s7.D    = d;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    s7.CEN = 1'b1;
  endtask

  task automatic drv10(input logic cen, input logic gwen, input logic [9:0] a,
                       input logic [15:0] wen, input logic [15:0] d);
    s10.CEN  = cen;
    s10.GWEN = gwen;
    s10.A    = a;
    s10.WEN  = wen;
    s10.D    = d;
    @(posedge clk);
    #1;
    s10.CEN = 1'b1;
  endtask

  task automatic wr7(input logic [6:0] a, input logic [15:0] d, input logic [15:0] wen);
    drv7(1'b0, 1'b0, 1'b0, a, wen, d);
  endtask

  task automatic rd7(input logic [6:0] a);
    drv7(1'b0, 1'b0, 1'b1, a, 16'h0000, 16'h0000);
  endtask

  logic [15:0] ones;
  logic [15:0] acc;
  logic [15:0] wt_exp;

  initial begin
    checks   = 0;
    failures = 0;
    ones     = 16'hFFFF;
    rst      = 1'b0;
    s7.CEN = 1'b1;  s7.GWEN = 1'b1;  s7.A = '0;  s7.WEN = '1;  s7.D = '0;
    s10.CEN = 1'b1; s10.GWEN = 1'b1; s10.A = '0; s10.WEN = '1; s10.D = '0;
    @(posedge clk);
    #1;

    // Reset clears Q on both instances
    drv7(1'b1, 1'b1, 1'b1, 7'd0, 16'hFFFF, 16'h0000);
    chk("reset_q7", s7.Q, 16'h0000);
    chk("reset_q10", s10.Q, 16'h0000);

    // Write then read back
    for (int i = 0; i < 10; i++) begin
      wr7(7'(i), 16'(i), 16'h0000);
      rd7(7'(i));
      chk("wr_rd", s7.Q, 16'(i));
    end

    // Write cycle without write-through leaves Q alone (Q currently 9)
`ifndef AQ_SPSRAM_WRITE_THROUGH_EN
    wr7(7'd0, 16'h0000, 16'hFFFF);
    chk("write_holds_q", s7.Q, 16'h0009);
`endif

    // Chip disable: writes and reads with CEN=1 do nothing
    for (int i = 10; i < 20; i++) wr7(7'(i), 16'h0000, 16'h0000);
    rd7(7'd9);
    chk("cen_prior", s7.Q, 16'h0009);
    for (int i = 10; i < 20; i++) begin
      drv7(1'b0, 1'b1, 1'b0, 7'(i), 16'h0000, 16'(i));
      chk("cen_wr_hold", s7.Q, 16'h0009);
      drv7(1'b0, 1'b1, 1'b1, 7'(i), 16'h0000, 16'h0000);
      chk("cen_rd_hold", s7.Q, 16'h0009);
    end
    for (int i = 10; i < 20; i++) begin
      rd7(7'(i));
      chk("cen_array", s7.Q, 16'h0000);
    end

    // Per-bit write mask, accumulating from the MSB down
    wr7(7'd20, 16'h0000, 16'h0000);
    acc = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      acc = acc | ~(ones >> k);
      wr7(7'd20, 16'hFFFF, ones >> k);
      rd7(7'd20);
      chk("bit_mask", s7.Q, acc);
    end
    chk("mask_k15", acc, 16'hFFFE);

    // Full sweep, 128 deep
    for (int a = 0; a < 128; a++) begin
      wr7(7'(a), 16'hFFFF, 16'h0000);
      rd7(7'(a));
      chk("sweep7", s7.Q, 16'hFFFF);
    end

    // Full sweep, 1024 deep
    for (int a = 0; a < 1024; a++) begin
      drv10(1'b0, 1'b0, 10'(a), 16'h0000, 16'hFFFF);
      drv10(1'b0, 1'b1, 10'(a), 16'h0000, 16'h0000);
      chk("sweep10", s10.Q, 16'hFFFF);
    end

    // Reset drops a coincident write; array survives
    wr7(7'd3, 16'h1234, 16'h0000);
    rd7(7'd3);
    chk("rst_pre", s7.Q, 16'h1234);
    drv7(1'b1, 1'b0, 1'b0, 7'd3, 16'h0000, 16'hBEEF);
    chk("rst_q", s7.Q, 16'h0000);
    drv7(1'b0, 1'b1, 1'b1, 7'd3, 16'h0000, 16'h0000);
    chk("rst_idle_hold", s7.Q, 16'h0000);
    rd7(7'd3);
    chk("rst_keep", s7.Q, 16'h1234);

    // Masked write over 0x0F0F with write-through behaviour per build
    wr7(7'd5, 16'h0F0F, 16'h0000);
    rd7(7'd5);
    chk("wt_pre", s7.Q, 16'h0F0F);
`ifdef AQ_SPSRAM_WRITE_THROUGH_EN
    wt_exp = 16'hA50F;
`else
    wt_exp = 16'h0F0F;
`endif
    wr7(7'd5, 16'hA5A5, 16'h00FF);
    chk("wt_q", s7.Q, wt_exp);
    rd7(7'd5);
    chk("wt_read", s7.Q, 16'hA50F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
